// File: rtl/vecarray_pkg.sv
// Shared types for the vector-shift tile array: opcodes, chain stage record,
// drain FSM states and the chain-length helper.
package vecarray_pkg;

    // Stage data is carried at this width; instances use the low REG_WIDTH bits.
    localparam int VA_DATA_W = 64;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_DRAIN = 2'd2,
        OP_CLEAR = 2'd3
    } opcode_e;

    typedef struct packed {
        logic [VA_DATA_W-1:0] data;
        logic                 is_data;
        logic                 is_last;
    } stage_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic int stage_count(input int reg_count, input int tile_height,
                                       input int intertile);
        int tot_tile;
        tot_tile = (reg_count + tile_height - 1) / tile_height;
        return reg_count + (tot_tile - 1) * intertile;
    endfunction

endpackage

// File: rtl/vecarray_stage.sv
// One chain stage: clear, load-from-successor on advance, or serial shift-in
// with an optional end-of-vector mark while idle.
module vecarray_stage
    import vecarray_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  logic   step_en,
    input  logic   clr,
    input  logic   adv,
    input  stage_t succ,
    input  logic   shift_en,
    input  logic   shift_bit,
    input  logic   set_last,
    output stage_t q
);

    stage_t stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else if (adv) begin
            stage_d = succ;
        end else begin
            if (shift_en) begin
                stage_d.data    = {stage_q.data[VA_DATA_W-2:0], shift_bit};
                stage_d.is_data = 1'b1;
            end
            if (set_last) begin
                stage_d.is_last = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
        end else if (step_en) begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/vecshift_array_pipe.sv
// Tiled bit-serial register array drained through tile 0 as a valid/ready stream.
// VECARRAY_DBG_STEP_EN: when defined, every update is gated by dbg_clk_enable.
module vecshift_array_pipe
    import vecarray_pkg::*;
#(
    parameter int REG_WIDTH       = 16,
    parameter int REG_COUNT       = 8,
    parameter int TILE_HEIGHT     = 4,
    parameter int INTERTILE_STAGE = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           instruction,
    input  logic                 inputValid,
    output logic                 instrReady,
    input  logic [REG_COUNT-1:0] serialIn,
    input  logic [REG_COUNT-1:0] serialIn_valid,
    output logic [REG_WIDTH-1:0] parallelOut,
    output logic                 outValid,
    output logic                 outLast,
    input  logic                 outReady,
    output logic                 busy,
    input  logic                 dbg_clk_enable
);

    localparam int N      = stage_count(REG_COUNT, TILE_HEIGHT, INTERTILE_STAGE);
    localparam int PERIOD = TILE_HEIGHT + INTERTILE_STAGE;

    logic step_en;
`ifdef VECARRAY_DBG_STEP_EN
    assign step_en = dbg_clk_enable;
`else
    logic unused_dbg;
    assign step_en    = 1'b1;
    assign unused_dbg = dbg_clk_enable;
`endif

    opcode_e op;
    state_e  state_q, state_d;
    stage_t  out_q, out_d;
    stage_t  chain_q [N];
    logic    clr, load, drain_start, adv, done;

    assign op = opcode_e'(instruction);

    always_comb begin
        clr         = inputValid && (op == OP_CLEAR);
        load        = inputValid && (state_q == ST_IDLE) && (op == OP_LOAD);
        drain_start = inputValid && (state_q == ST_IDLE) && (op == OP_DRAIN);
        adv         = (state_q == ST_DRAIN) && (!out_q.is_data || outReady);
        // The marker leaves either with the handshake of a data word or as a
        // discarded empty slot at the head of the chain.
        done        = adv && ((out_q.is_data && out_q.is_last) ||
                              (chain_q[0].is_last && !chain_q[0].is_data));
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (clr) begin
            state_d = ST_IDLE;
            out_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (drain_start) state_d = ST_DRAIN;
                ST_DRAIN: if (done)        state_d = ST_IDLE;
                default:                   state_d = ST_IDLE;
            endcase
            if (adv) begin
                out_d = chain_q[0].is_data ? chain_q[0] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
        end else if (step_en) begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    for (genvar s = 0; s < N; s++) begin : g_stage
        // Stage s is a register when its offset within a tile period is below
        // TILE_HEIGHT; the remaining slots of each period are pipeline stages.
        localparam bit IS_REG = (s % PERIOD) < TILE_HEIGHT;
        localparam int RIDX   = (s / PERIOD) * TILE_HEIGHT + (s % PERIOD);

        stage_t succ;
        logic   sh_en, sh_bit, mark;

        if (s == N - 1) begin : g_tail
            assign succ = '0;
            assign mark = drain_start;
        end else begin : g_body
            assign succ = chain_q[s+1];
            assign mark = 1'b0;
        end

        if (IS_REG) begin : g_reg
            assign sh_en  = load && serialIn_valid[RIDX];
            assign sh_bit = serialIn[RIDX];
        end else begin : g_pipe
            assign sh_en  = 1'b0;
            assign sh_bit = 1'b0;
        end

        vecarray_stage u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .step_en   (step_en),
            .clr       (clr),
            .adv       (adv),
            .succ      (succ),
            .shift_en  (sh_en),
            .shift_bit (sh_bit),
            .set_last  (mark),
            .q         (chain_q[s])
        );
    end

    if (REG_WIDTH < VA_DATA_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^out_q.data[VA_DATA_W-1:REG_WIDTH];
    end

    assign parallelOut = out_q.data[REG_WIDTH-1:0];
    assign outValid    = out_q.is_data;
    assign outLast     = out_q.is_data && out_q.is_last;
    assign busy        = (state_q == ST_DRAIN);
    assign instrReady  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vecshift_array_pipe.sv
// Directed bench for vecshift_array_pipe: 6 registers of 8 bits, tiles of 4,
// one intertile stage (7-stage chain).
module tb_vecshift_array_pipe;

    localparam int W  = 8;
    localparam int RC = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    instruction;
    logic          inputValid;
    logic          instrReady;
    logic [RC-1:0] serialIn;
    logic [RC-1:0] serialIn_valid;
    logic [W-1:0]  parallelOut;
    logic          outValid;
    logic          outLast;
    logic          outReady;
    logic          busy;
    logic          dbg_clk_enable;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] got_w[$];
    logic         got_l[$];
    int           idle_k;

    vecshift_array_pipe #(
        .REG_WIDTH(W), .REG_COUNT(RC), .TILE_HEIGHT(4), .INTERTILE_STAGE(1)
    ) dut (
        .clk(clk), .rstn(rstn), .instruction(instruction), .inputValid(inputValid),
        .instrReady(instrReady), .serialIn(serialIn), .serialIn_valid(serialIn_valid),
        .parallelOut(parallelOut), .outValid(outValid), .outLast(outLast),
        .outReady(outReady), .busy(busy), .dbg_clk_enable(dbg_clk_enable)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instruction    = 2'd0;
        inputValid     = 1'b0;
        serialIn       = '0;
        serialIn_valid = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        outReady       = 1'b1;
        dbg_clk_enable = 1'b1;
        rstn           = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    // Register i receives base+i, MSB first, when mask[i] is set.
    task automatic load_regs(input logic [RC-1:0] mask, input logic [W-1:0] base);
        logic [W-1:0] v;
        for (int b = W - 1; b >= 0; b--) begin
            instruction    = 2'd1;
            inputValid     = 1'b1;
            serialIn_valid = mask;
            for (int i = 0; i < RC; i++) begin
                v = base + W'(i);
                serialIn[i] = v[b];
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic issue_drain();
        instruction = 2'd2;
        inputValid  = 1'b1;
        step();
        idle_inputs();
    endtask

    // Records handshaken words until busy drops; idle_k is the cycle it dropped.
    task automatic collect(input logic [3:0] pat, input int maxc);
        got_w.delete();
        got_l.delete();
        idle_k = -1;
        for (int k = 0; k < maxc; k++) begin
            outReady = pat[k%4];
            if (!busy) begin
                idle_k = k;
                break;
            end
            if (outValid && outReady) begin
                got_w.push_back(parallelOut);
                got_l.push_back(outLast);
            end
            step();
        end
        outReady = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (parallelOut !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", parallelOut); end
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", outValid); end
        total++; if (outLast !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b exp=0", outLast); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (instrReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", instrReady); end
    endtask

    task automatic test_basic();
        logic [8:0] ev, el, eb;
        logic [7:0] ed [9];
        ev = 9'b011011110;
        el = 9'b010000000;
        eb = 9'b011111111;
        ed = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00};
        do_reset();
        load_regs(6'b111111, 8'h10);
        outReady = 1'b1;
        issue_drain();
        for (int k = 0; k < 9; k++) begin
            total++; if (outValid !== ev[k]) begin bad++; $display("FAIL basic_valid k=%0d got=%0b exp=%0b", k, outValid, ev[k]); end
            if (ev[k]) begin
                total++; if (parallelOut !== ed[k]) begin bad++; $display("FAIL basic_data k=%0d got=%0h exp=%0h", k, parallelOut, ed[k]); end
            end
            total++; if (outLast !== el[k]) begin bad++; $display("FAIL basic_last k=%0d got=%0b exp=%0b", k, outLast, el[k]); end
            total++; if (busy !== eb[k]) begin bad++; $display("FAIL basic_busy k=%0d got=%0b exp=%0b", k, busy, eb[k]); end
            total++; if (instrReady !== !eb[k]) begin bad++; $display("FAIL basic_ready k=%0d got=%0b exp=%0b", k, instrReady, !eb[k]); end
            step();
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        logic       prev_stall;
        logic [7:0] prev_d;
        int         finished;
        pat        = 4'b1001;
        prev_stall = 1'b0;
        prev_d     = '0;
        finished   = 0;
        got_w.delete();
        got_l.delete();
        do_reset();
        load_regs(6'b111111, 8'h10);
        issue_drain();
        for (int k = 0; k < 80; k++) begin
            outReady = pat[k%4];
            if (prev_stall) begin
                total++; if (outValid !== 1'b1 || parallelOut !== prev_d) begin
                    bad++; $display("FAIL stall_hold k=%0d got=%0b/%0h exp=1/%0h", k, outValid, parallelOut, prev_d);
                end
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            if (outValid && outReady) begin
                got_w.push_back(parallelOut);
                got_l.push_back(outLast);
            end
            prev_stall = outValid && !outReady;
            prev_d     = parallelOut;
            step();
        end
        outReady = 1'b1;
        total++; if (finished != 1) begin bad++; $display("FAIL stall_timeout got=%0d exp=1", finished); end
        total++; if (got_w.size() != 6) begin bad++; $display("FAIL stall_count got=%0d exp=6", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < 6; i++) begin
            total++; if (got_w[i] !== 8'h10 + 8'(i) || got_l[i] !== (i == 5)) begin
                bad++; $display("FAIL stall_word i=%0d got=%0h/%0b exp=%0h/%0b", i, got_w[i], got_l[i], 8'h10 + 8'(i), (i == 5));
            end
        end
    endtask

    task automatic test_sparse();
        do_reset();
        load_regs(6'b100010, 8'hA0);
        issue_drain();
        collect(4'b1111, 20);
        total++; if (idle_k != 8) begin bad++; $display("FAIL sparse_idle got=%0d exp=8", idle_k); end
        total++; if (got_w.size() != 2) begin bad++; $display("FAIL sparse_count got=%0d exp=2", got_w.size()); end
        if (got_w.size() == 2) begin
            total++; if (got_w[0] !== 8'hA1 || got_l[0] !== 1'b0) begin bad++; $display("FAIL sparse_w0 got=%0h/%0b exp=a1/0", got_w[0], got_l[0]); end
            total++; if (got_w[1] !== 8'hA5 || got_l[1] !== 1'b1) begin bad++; $display("FAIL sparse_w1 got=%0h/%0b exp=a5/1", got_w[1], got_l[1]); end
        end
    endtask

    task automatic test_no_last();
        do_reset();
        load_regs(6'b011111, 8'h10);
        issue_drain();
        collect(4'b1111, 20);
        total++; if (idle_k != 7) begin bad++; $display("FAIL nolast_idle got=%0d exp=7", idle_k); end
        total++; if (got_w.size() != 5) begin bad++; $display("FAIL nolast_count got=%0d exp=5", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < 5; i++) begin
            total++; if (got_w[i] !== 8'h10 + 8'(i) || got_l[i] !== 1'b0) begin
                bad++; $display("FAIL nolast_word i=%0d got=%0h/%0b exp=%0h/0", i, got_w[i], got_l[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        load_regs(6'b111111, 8'h10);
        issue_drain();
        step(); step(); step();
        total++; if (outValid !== 1'b1 || parallelOut !== 8'h12) begin bad++; $display("FAIL clear_pre got=%0b/%0h exp=1/12", outValid, parallelOut); end
        instruction = 2'd3;
        inputValid  = 1'b1;
        outReady    = 1'b1;
        step();
        idle_inputs();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%0b exp=0", outValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%0b exp=0", busy); end
        total++; if (parallelOut !== 8'h00) begin bad++; $display("FAIL clear_data got=%0h exp=0", parallelOut); end
        total++; if (instrReady !== 1'b1) begin bad++; $display("FAIL clear_ready got=%0b exp=1", instrReady); end
        issue_drain();
        collect(4'b1111, 20);
        total++; if (got_w.size() != 0) begin bad++; $display("FAIL clear_redrain_count got=%0d exp=0", got_w.size()); end
        total++; if (idle_k != 7) begin bad++; $display("FAIL clear_redrain_idle got=%0d exp=7", idle_k); end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_regs(6'b111111, 8'h10);
        issue_drain();
        step(); step(); step();
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0b exp=1", outValid); end
        rstn = 1'b0;
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", outValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        total++; if (parallelOut !== 8'h00) begin bad++; $display("FAIL arst_data got=%0h exp=0", parallelOut); end
        total++; if (instrReady !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0b exp=1", instrReady); end
        #1;
        rstn = 1'b1;
        issue_drain();
        collect(4'b1111, 20);
        total++; if (got_w.size() != 0) begin bad++; $display("FAIL arst_redrain_count got=%0d exp=0", got_w.size()); end
        total++; if (idle_k != 7) begin bad++; $display("FAIL arst_redrain_idle got=%0d exp=7", idle_k); end
    endtask

    task automatic test_load_during_drain();
        do_reset();
        load_regs(6'b111111, 8'h10);
        outReady = 1'b0;
        issue_drain();
        step();
        for (int c = 0; c < 4; c++) begin
            instruction    = (c == 3) ? 2'd2 : 2'd1;
            inputValid     = 1'b1;
            serialIn       = '1;
            serialIn_valid = '1;
            total++; if (instrReady !== 1'b0 || parallelOut !== 8'h10) begin
                bad++; $display("FAIL ldrain_hold c=%0d got=%0b/%0h exp=0/10", c, instrReady, parallelOut);
            end
            step();
        end
        idle_inputs();
        collect(4'b1111, 30);
        total++; if (idle_k < 0) begin bad++; $display("FAIL ldrain_timeout got=%0d exp>=0", idle_k); end
        total++; if (got_w.size() != 6) begin bad++; $display("FAIL ldrain_count got=%0d exp=6", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < 6; i++) begin
            total++; if (got_w[i] !== 8'h10 + 8'(i) || got_l[i] !== (i == 5)) begin
                bad++; $display("FAIL ldrain_word i=%0d got=%0h/%0b exp=%0h/%0b", i, got_w[i], got_l[i], 8'h10 + 8'(i), (i == 5));
            end
        end
    endtask

    task automatic test_dbg_step();
        do_reset();
        load_regs(6'b111111, 8'h10);
        issue_drain();
        step(); step();
        dbg_clk_enable = 1'b0;
`ifdef VECARRAY_DBG_STEP_EN
        for (int c = 0; c < 5; c++) begin
            step();
            total++; if (outValid !== 1'b1 || parallelOut !== 8'h11 || busy !== 1'b1) begin
                bad++; $display("FAIL dbg_freeze c=%0d got=%0b/%0h/%0b exp=1/11/1", c, outValid, parallelOut, busy);
            end
        end
        dbg_clk_enable = 1'b1;
        collect(4'b1111, 20);
        total++; if (got_w.size() != 5) begin bad++; $display("FAIL dbg_count got=%0d exp=5", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < 5; i++) begin
            total++; if (got_w[i] !== 8'h11 + 8'(i) || got_l[i] !== (i == 4)) begin
                bad++; $display("FAIL dbg_word i=%0d got=%0h/%0b exp=%0h/%0b", i, got_w[i], got_l[i], 8'h11 + 8'(i), (i == 4));
            end
        end
`else
        repeat (5) step();
        total++; if (outValid !== 1'b1 || parallelOut !== 8'h15 || outLast !== 1'b1) begin
            bad++; $display("FAIL dbg_ignored got=%0b/%0h/%0b exp=1/15/1", outValid, parallelOut, outLast);
        end
        collect(4'b1111, 20);
        dbg_clk_enable = 1'b1;
        total++; if (got_w.size() != 1) begin bad++; $display("FAIL dbg_tail_count got=%0d exp=1", got_w.size()); end
        total++; if (idle_k != 1) begin bad++; $display("FAIL dbg_tail_idle got=%0d exp=1", idle_k); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_sparse();
        test_no_last();
        test_clear();
        test_async_reset();
        test_load_during_drain();
        test_dbg_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/vecshift_array_pipe.md
# vecshift_array_pipe

Parametrised successor to the vector-shift tile array. It holds REG_COUNT bit-serially loaded registers of REG_WIDTH bits, grouped into tiles of TILE_HEIGHT, with INTERTILE_STAGE real pipeline registers between consecutive tiles. On a DRAIN instruction it streams the loaded words out of tile 0 as a valid/ready stream with backpressure and an end-of-vector marker. It sits between the serial bit-plane producers and the upstream vector consumer.

## Interface
- REG_WIDTH, 16, bits per register
- REG_COUNT, 8, total registers (>0)
- TILE_HEIGHT, 4, registers per tile (>0); last tile may be partial
- INTERTILE_STAGE, 1, pipeline stages between tiles (>=0)
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- instruction  in  2  opcode: 0 NOP, 1 LOAD, 2 DRAIN, 3 CLEAR
- inputValid  in  1  instruction and serial inputs valid this cycle
- instrReady  out  1  LOAD/DRAIN accepted this cycle (=state IDLE)
- serialIn  in  REG_COUNT  one serial bit per register, MSB first
- serialIn_valid  in  REG_COUNT  per-register bit valid
- parallelOut  out  REG_WIDTH  output word
- outValid  out  1  parallelOut holds a data word
- outLast  out  1  word is register REG_COUNT-1
- outReady  in  1  consumer accepts word
- busy  out  1  drain in progress
- dbg_clk_enable  in  1  debug step enable

## Operation
- Chain: N = REG_COUNT + (TOT_TILE-1)*INTERTILE_STAGE stages, TOT_TILE = ceil(REG_COUNT/TILE_HEIGHT). Each stage holds {data, isData, isLast}. Stage 0 is register 0.
- FSM states IDLE and DRAIN.
- IDLE, LOAD with inputValid: for each i with serialIn_valid[i], reg_i <= {reg_i[W-2:0], serialIn[i]} and isData_i <= 1. Other registers are unchanged. Pipeline stages stay empty.
- IDLE, DRAIN with inputValid: the state goes to DRAIN and isLast is set on register REG_COUNT-1.
- CLEAR with inputValid, in any state: all stages, flags and the output register go to 0 and the state goes to IDLE. This aborts a drain.
- DRAIN: advance = !outValid || outReady. On advance, every stage copies its successor, stage N-1 takes zeros, and the output register takes stage 0.
- outValid is set only when stage 0 has isData set. Bubbles and empty registers are skipped silently.
- DRAIN to IDLE happens when the isLast marker leaves the chain:
  - if the last word is data, on the handshake of the outLast word;
  - otherwise on the advance that discards it.
- LOAD or DRAIN issued during DRAIN: ignored (instrReady=0) and has no effect.
- NOP: no effect.

## Timing
- Reset values: parallelOut=0, outValid=0, outLast=0, busy=0, instrReady=1, all stages 0, state IDLE.
- LOAD: the bit is visible in reg_i the next cycle. REG_WIDTH LOAD cycles fill a word.
- First word: outValid rises 1 cycle after DRAIN is accepted, if register 0 has data.
- Without stalls, the word from stage k appears k+1 cycles after accept. The last word appears N cycles after accept.
- Stalls: while outValid && !outReady, the whole chain and the output register hold.
- busy is high from the cycle after DRAIN is accepted until the cycle after the marker leaves. instrReady is its complement.
- Simultaneous CLEAR and outReady handshake: CLEAR wins and the word is dropped.
- rstn asserted mid-drain: immediate asynchronous clear to reset values.

## Configuration
- VECARRAY_DBG_STEP_EN defined: every sequential update, including FSM, chain and output, is qualified by dbg_clk_enable. Cycles with dbg_clk_enable=0 are frozen. Asynchronous reset is unaffected.
- Not defined: dbg_clk_enable is ignored and updates occur every clock.

## Structure
- Package vecarray_pkg contains:
  - opcode enum (NOP/LOAD/DRAIN/CLEAR);
  - stage struct {data, isData, isLast};
  - FSM state enum;
  - stage-count helper function.
- Sub-module vecarray_stage: one chain stage register with load-from-successor, serial-shift and clear controls. It is instantiated N times; pipeline stages tie the shift inputs off.

## Test plan
- Config REG_WIDTH=8, REG_COUNT=6, TILE_HEIGHT=4, INTERTILE_STAGE=1 (N=7). Load register i with 0x10+i over 8 LOAD cycles, DRAIN, outReady=1:
  - words 0x10..0x15 appear in order;
  - one bubble between 0x13 and 0x14;
  - outLast only on 0x15;
  - busy drops after it.
- Same load, outReady toggles 1,0,0,1 repeatedly: no word is lost or duplicated and parallelOut is stable while stalled.
- Load only registers 1 and 5 (0xA1, 0xA5), DRAIN: exactly two words, with outLast on 0xA5.
- Load registers 0–4 only, DRAIN: five words, no outLast, and busy falls 7 cycles after accept.
- CLEAR three cycles into a drain with outValid=1: next cycle outValid=0, busy=0 and all registers read 0 on a subsequent drain. Separately, pulse rstn low mid-drain: same result, asynchronously.
- With VECARRAY_DBG_STEP_EN: hold dbg_clk_enable=0 for 5 cycles mid-drain and outputs are frozen; re-enable and the sequence resumes intact. Also issue LOAD during DRAIN: no register changes.
